rom_stream_reader: RTL

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

---
 rtl/rom_stream_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - burst reader from a synchronous ROM into a ready/valid stream
// Reads are credit-limited so the 2-entry FIFO plus the one inflight read never exceeds two words.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ROM_CEN,
  output logic [ADDR_WIDTH-1:0] ROM_A,
  input  logic [DATA_WIDTH-1:0] ROM_Q,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_LAST
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_to_issue;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_head_last;

  assign w_pop       = (r_count != 2'd0) && OUT_READY;
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == S_FETCH) && (r_to_issue != '0) && (w_occ < 3'd2);
  assign w_head_last = r_fifo_last[r_rd_ptr];

  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_FINISH);
  assign ROM_CEN   = ~w_issue;
  assign ROM_A     = r_addr;
  assign OUT_VALID = (r_count != 2'd0);
  assign OUT_DATA  = r_fifo_data[r_rd_ptr];
  assign OUT_LAST  = OUT_VALID && w_head_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next = (LEN == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_pop && w_head_last) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The ROM answers one cycle after the issue edge, so the inflight flag marks the push edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr          <= '0;
      r_to_issue      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= 2'b00;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      if (r_state == S_IDLE && START) begin
        r_addr     <= BASE_ADDR;
        r_to_issue <= LEN;
      end else if (w_issue) begin
        r_addr     <= r_addr + ADDR_ONE;
        r_to_issue <= r_to_issue - LEN_ONE;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_to_issue == LEN_ONE);
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= ROM_Q;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
